// File: rtl/fe_tobytes.sv
// rtl/fe_tobytes.sv - canonical reduction and little-endian byte packing of a 10-limb field element
//
// Reduces a signed radix-2^25.5 field element mod p = 2^255-19 to canonical
// form and packs it into 32 little-endian bytes. One add/shift/carry step is
// performed per clock, so an operation takes 24 cycles from accept to done.
//
// Ports:
//   clk    system clock, rising edge
//   rst    asynchronous active-high reset
//   in     limb h_i at in[i*32 +: 32], signed, i = 0..9
//   valid  start request, sampled while ready = 1
//   ready  high while idle
//   out    byte k at out[k*8 +: 8], held until the next result
//   done   one-cycle pulse when out is updated
//   isneg  out[0], present only when FE_TOBYTES_ISNEG_EN is defined
//
// Optional feature macro: FE_TOBYTES_ISNEG_EN

module fe_tobytes (
  input  logic         clk,
  input  logic         rst,
  input  logic [319:0] in,
  input  logic         valid,
  output logic         ready,
  output logic [255:0] out,
  output logic         done
`ifdef FE_TOBYTES_ISNEG_EN
  ,
  output logic         isneg
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_QINIT  = 3'd1,
    S_QCHAIN = 3'd2,
    S_FOLD   = 3'd3,
    S_CARRY  = 3'd4,
    S_PACK   = 3'd5
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [3:0]         cnt;
  logic signed [63:0] h [10];
  logic signed [63:0] q;
  logic signed [63:0] hj;
  logic signed [63:0] carry;
  logic [4:0]         wj;

  // Limb selected by the step counter, its width, and its outgoing carry.
  // The same selection serves both the q chain and the carry chain.
  always_comb begin
    hj = '0;
    for (int i = 0; i < 10; i++) begin
      if (cnt == 4'(i)) hj = h[i];
    end
    wj    = cnt[0] ? 5'd25 : 5'd26;
    carry = hj >>> wj;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = S_IDLE;
    case (state)
      S_IDLE:   state_nx = valid ? S_QINIT : S_IDLE;
      S_QINIT:  state_nx = S_QCHAIN;
      S_QCHAIN: state_nx = (cnt == 4'd9) ? S_FOLD : S_QCHAIN;
      S_FOLD:   state_nx = S_CARRY;
      S_CARRY:  state_nx = (cnt == 4'd9) ? S_PACK : S_CARRY;
      S_PACK:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    ready = (state == S_IDLE);
  end

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 10; i++) h[i] <= '0;
      q    <= '0;
      cnt  <= '0;
      out  <= '0;
      done <= 1'b0;
`ifdef FE_TOBYTES_ISNEG_EN
      isneg <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (valid) begin
            for (int i = 0; i < 10; i++)
              h[i] <= {{32{in[i*32+31]}}, in[i*32 +: 32]};
          end
        end
        S_QINIT: begin
          // Estimate of floor(h / p): 0 or 1 (or -1 for slightly negative h).
          q   <= (64'sd19 * h[9] + 64'sd16777216) >>> 25;
          cnt <= 4'd0;
        end
        S_QCHAIN: begin
          q   <= (hj + q) >>> wj;
          cnt <= (cnt == 4'd9) ? 4'd0 : cnt + 4'd1;
        end
        S_FOLD: begin
          // Subtracting q*p equals adding 19*q here and dropping q*2^255
          // at the top of the carry chain.
          h[0] <= h[0] + 64'sd19 * q;
          cnt  <= 4'd0;
        end
        S_CARRY: begin
          // Step 9 keeps only the low 25 bits of h9; its carry is the q*2^255
          // term and has no destination limb.
          for (int i = 0; i < 10; i++) begin
            if (cnt == 4'(i))
              h[i] <= hj - (carry <<< wj);
            else if (i > 0 && cnt == 4'(i - 1))
              h[i] <= h[i] + carry;
          end
          cnt <= (cnt == 4'd9) ? 4'd0 : cnt + 4'd1;
        end
        S_PACK: begin
          out <= {1'b0, h[9][24:0], h[8][25:0], h[7][24:0], h[6][25:0],
                  h[5][24:0], h[4][25:0], h[3][24:0], h[2][25:0],
                  h[1][24:0], h[0][25:0]};
          done <= 1'b1;
`ifdef FE_TOBYTES_ISNEG_EN
          isneg <= h[0][0];
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
